inst_fetch_queue: RTL

- Parametrised successor to the single-slot instruction fetcher, sitting between the instruction cache and the instruction decoder.
- Fetches sequentially from the PC into a QUEUE_DEPTH-entry instruction queue that carries {pc, inst} pairs.
- Recognises control-flow instructions (JAL, JALR, BRANCH), stops fetching after enqueuing one, and resumes from the target PC carried on the common data bus.
- Decouples cache latency from decoder back-pressure.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/inst_queue.sv | 74 +++++++
 rtl/inst_fetch_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch queue:
//   - FSM state encodings for the fetch controller
//   - RISC-V control-flow opcode constants
//   - is_ctrl_flow(): true when an opcode ends sequential fetch
// ----------------------------------------------------------------------------
package fetch_pkg;

  // Fetch FSM state encodings. These values are kept fixed so that external
  // debug tooling can continue to decode them.
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] WAIT_MEM = 2'b01;
  localparam logic [1:0] STALL    = 2'b11;

  // Control-flow opcodes, taken from inst[6:0].
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Returns true when the fetcher must stop and wait for a resolved target.
  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
// Parametrised circular FIFO holding {pc, inst} entries for the decoder.
// DEPTH must be a power of two and at least 2, so that the read and write
// pointers wrap naturally.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset (clears pointers and count)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   entry to enqueue
//   pop        in   drop the head entry (ignored when empty)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of valid entries
//   head_data  out  entry at the head (don't-care when empty)
// ----------------------------------------------------------------------------
module inst_queue #(
  parameter int DATA_WIDTH = 49,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_en;
  logic                  pop_en;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; an entry is only ever
  // read after it has been written, and resetting it would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide, so +1 wraps modulo DEPTH.
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or push+pop cancelling out
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
// Sequential instruction fetcher that feeds a QUEUE_DEPTH-entry {pc, inst}
// queue between the instruction cache and the decoder. Fetching stops after
// a control-flow instruction (JAL/JALR/BRANCH) is enqueued, and resumes at
// the target PC delivered on the common data bus.
//
// Ports:
//   clk                    in   system clock
//   rst                    in   asynchronous active-low reset
//   rdy                    in   CPU ready; when low all state holds
//   cdb_valid              in   cdb_data holds the resolved next PC
//   cdb_data               in   redirect PC in bits [ADDR_WIDTH-1:0]
//   inst_cache_read_valid  out  fetch request (held until done)
//   inst_cache_read_addr   out  fetch address (the PC)
//   inst_cache_read_done   in   one-cycle pulse, read data valid
//   inst_cache_read_data   in   fetched instruction
//   inst_decode_ready      in   decoder takes the head entry this cycle
//   inst_decode_valid      out  queue not empty
//   inst_decode_data       out  instruction at the queue head
//   inst_decode_pc         out  PC of the queue head
// ----------------------------------------------------------------------------
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    INST_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 17,
  parameter int                    CDB_WIDTH   = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  cdb_valid,
  input  logic [CDB_WIDTH-1:0]  cdb_data,
  output logic                  inst_cache_read_valid,
  output logic [ADDR_WIDTH-1:0] inst_cache_read_addr,
  input  logic                  inst_cache_read_done,
  input  logic [INST_WIDTH-1:0] inst_cache_read_data,
  input  logic                  inst_decode_ready,
  output logic                  inst_decode_valid,
  output logic [INST_WIDTH-1:0] inst_decode_data,
  output logic [ADDR_WIDTH-1:0] inst_decode_pc
);

  localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_nxt;

  logic                  q_push;
  logic                  q_pop;
  logic                  q_full;
  logic                  q_empty;
  logic [CNT_W-1:0]      q_count;
  logic [ENTRY_W-1:0]    q_head;

  // Only the low ADDR_WIDTH bits of the CDB carry the redirect PC.
  logic unused_cdb_hi;
  assign unused_cdb_hi = ^cdb_data[CDB_WIDTH-1:ADDR_WIDTH];

  // Queue control. A request is only issued while count < QUEUE_DEPTH and the
  // count cannot rise before the response lands, so q_full never actually
  // blocks a push; it is kept as a guard.
  assign q_push = rdy && (state == WAIT_MEM) && inst_cache_read_done && !q_full;
  assign q_pop  = rdy && inst_decode_ready && !q_empty;

  inst_queue #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({pc, inst_cache_read_data}),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head_data (q_head)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: begin
        if (q_count < CNT_W'(QUEUE_DEPTH)) state_nxt = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (inst_cache_read_done) begin
          if (is_ctrl_flow(inst_cache_read_data[6:0])) begin
            // Hold the PC; the real target arrives on the CDB.
            state_nxt = STALL;
          end else begin
            pc_nxt    = pc + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
            state_nxt = IDLE;
          end
        end
      end
      STALL: begin
        // Redirect target is taken as-is, including misaligned values.
        if (cdb_valid) begin
          pc_nxt    = cdb_data[ADDR_WIDTH-1:0];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;  // unused encoding 2'b10
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (rdy) begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  assign inst_cache_read_valid = (state == WAIT_MEM);
  assign inst_cache_read_addr  = pc;
  assign inst_decode_valid     = !q_empty;
  assign inst_decode_pc        = q_head[ENTRY_W-1:INST_WIDTH];
  assign inst_decode_data      = q_head[INST_WIDTH-1:0];

endmodule
